// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants and stage record for the FP add/sub datapath
package fp_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int MANT_W_DEF = 24;
  localparam int TAG_W_DEF  = 4;

  // Sign/operation part of the stage record; mantissa and tag widths are
  // stage parameters, so those fields live next to it in each stage.
  typedef struct packed {
    logic a_sign;
    logic b_sign;
    logic op;
    logic eff_sub;
  } fp_ctl_t;

  // Magnitudes are subtracted when the signs (after applying op) differ.
  function automatic logic eff_sub_f(input logic a_sign, input logic b_sign, input logic op);
    return a_sign ^ b_sign ^ (op == OP_SUB);
  endfunction

endpackage

// File: rtl/fp_mag_addsub.sv
// rtl/fp_mag_addsub.sv - combinational magnitude compare and add/subtract/negate-select
module fp_mag_addsub #(
  parameter int MANT_W = 24
) (
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  input  logic              eff_sub,
  output logic [MANT_W:0]   mag,
  output logic              a_lt_b,
  output logic              a_eq_b
);

  logic [MANT_W:0]   sum;
  logic [MANT_W:0]   diff;
  logic [MANT_W-1:0] neg_diff;

  assign sum = {1'b0, a} + {1'b0, b};

  // a + ~b + 1: the carry-out is set exactly when a >= b, so the same
  // adder gives both the difference and the magnitude comparison.
  assign diff     = {1'b0, a} + {1'b0, ~b} + {{MANT_W{1'b0}}, 1'b1};
  assign a_lt_b   = ~diff[MANT_W];
  assign a_eq_b   = (a == b);
  assign neg_diff = ~diff[MANT_W-1:0] + {{(MANT_W-1){1'b0}}, 1'b1};

  // Select sum, a-b, or b-a (the negated difference) as the magnitude
  always_comb begin
    mag = sum;
    if (eff_sub) begin
      mag = {1'b0, (a_lt_b ? neg_diff : diff[MANT_W-1:0])};
    end
  end

endmodule

// File: rtl/fp_signmag_pipe.sv
// rtl/fp_signmag_pipe.sv - two-stage sign / effective-op / magnitude pipeline
module fp_signmag_pipe
  import fp_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_a_sign,
  input  logic              in_b_sign,
  input  logic [MANT_W-1:0] in_a_mant,
  input  logic [MANT_W-1:0] in_b_mant,
  input  logic              in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic              out_eff_sub,
  output logic [MANT_W:0]   out_mag,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag
);

  logic              s1_valid;
  fp_ctl_t           s1_ctl;
  logic [MANT_W-1:0] s1_a;
  logic [MANT_W-1:0] s1_b;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_load_en;
  logic              s1_advance;
  logic [MANT_W:0]   mag_next;
  logic              a_lt_b;
  logic              a_eq_b;
  logic              sign_next;

  // S2 may take new data when empty or when its current result leaves now.
  assign s2_load_en = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_load_en;
  assign in_ready   = !s1_valid || s1_advance;

  // S1: capture operands, tag and effective operation on input transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ctl   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ctl.a_sign  <= in_a_sign;
        s1_ctl.b_sign  <= in_b_sign;
        s1_ctl.op      <= in_op;
        s1_ctl.eff_sub <= eff_sub_f(in_a_sign, in_b_sign, in_op);
        s1_a           <= in_a_mant;
        s1_b           <= in_b_mant;
        s1_tag         <= in_tag;
      end
    end
  end

  fp_mag_addsub #(
    .MANT_W (MANT_W)
  ) u_mag (
    .a       (s1_a),
    .b       (s1_b),
    .eff_sub (s1_ctl.eff_sub),
    .mag     (mag_next),
    .a_lt_b  (a_lt_b),
    .a_eq_b  (a_eq_b)
  );

  // Result sign: exact cancellation gives +0; otherwise the larger operand's sign wins
  always_comb begin
    sign_next = s1_ctl.a_sign;
    if (s1_ctl.eff_sub) begin
      if (a_eq_b) begin
        sign_next = 1'b0;
      end else if (a_lt_b) begin
        sign_next = s1_ctl.b_sign ^ (s1_ctl.op != OP_ADD);
      end
    end
  end

  // S2: output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_eff_sub <= 1'b0;
      out_mag     <= '0;
      out_zero    <= 1'b0;
      out_tag     <= '0;
    end else if (s2_load_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign    <= sign_next;
        out_eff_sub <= s1_ctl.eff_sub;
        out_mag     <= mag_next;
        out_zero    <= (mag_next == '0);
        out_tag     <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_signmag_pipe.sv
// tb/tb_fp_signmag_pipe.sv - self-checking bench for fp_signmag_pipe
module tb_fp_signmag_pipe;

  localparam int MW = 24;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_a_sign;
  logic          in_b_sign;
  logic [MW-1:0] in_a_mant;
  logic [MW-1:0] in_b_mant;
  logic          in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic          out_eff_sub;
  logic [MW:0]   out_mag;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  fp_signmag_pipe #(.MANT_W(MW), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a_sign   (in_a_sign),
    .in_b_sign   (in_b_sign),
    .in_a_mant   (in_a_mant),
    .in_b_mant   (in_b_mant),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_eff_sub (out_eff_sub),
    .out_mag     (out_mag),
    .out_zero    (out_zero),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sign;
    logic          eff_sub;
    logic [MW:0]   mag;
    logic          zero;
    logic [TW-1:0] tag;
  } res_t;

  typedef struct {
    logic          as;
    logic          bs;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          op;
    logic [TW-1:0] tag;
    res_t          exp;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  res_t exp_q[$];
  res_t held;
  bit   held_valid = 0;
  vec_t vt[10];

  // Signed-arithmetic reference: A + (+/-)B computed as plain integers.
  function automatic res_t model(input logic as, input logic bs, input logic [MW-1:0] a,
                                 input logic [MW-1:0] b, input logic op, input logic [TW-1:0] tag);
    res_t   r;
    longint va;
    longint vb;
    longint s;
    longint m;
    va = a;
    vb = b;
    if (as) va = -va;
    if (bs ^ op) vb = -vb;
    s = va + vb;
    m = (s < 0) ? -s : s;
    r.eff_sub = as ^ bs ^ op;
    r.mag     = m[MW:0];
    r.zero    = (m == 0);
    if (s < 0)      r.sign = 1'b1;
    else if (s > 0) r.sign = 1'b0;
    else            r.sign = r.eff_sub ? 1'b0 : as;
    r.tag = tag;
    return r;
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.sign    = out_sign;
    r.eff_sub = out_eff_sub;
    r.mag     = out_mag;
    r.zero    = out_zero;
    r.tag     = out_tag;
    return r;
  endfunction

  task automatic check_res(input string name, input res_t got, input res_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got sign=%0b eff_sub=%0b mag=%h zero=%0b tag=%h required sign=%0b eff_sub=%0b mag=%h zero=%0b tag=%h",
               name, got.sign, got.eff_sub, got.mag, got.zero, got.tag,
               exp.sign, exp.eff_sub, exp.mag, exp.zero, exp.tag);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %0b required %0b", name, got, exp);
    end
  endtask

  // One clock: scoreboard/stability observation at negedge, then return #1 after posedge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      held_valid = 0;
    end else begin
      if (held_valid) check_res("stall_hold", cur_out(), held);
      if (in_valid && in_ready)
        exp_q.push_back(model(in_a_sign, in_b_sign, in_a_mant, in_b_mant, in_op, in_tag));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_bit("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_res("scoreboard", cur_out(), e);
        end
      end
      held_valid = out_valid && !out_ready;
      held       = cur_out();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic as, input logic bs, input logic [MW-1:0] a,
                        input logic [MW-1:0] b, input logic op, input logic [TW-1:0] tag);
    in_a_sign = as;
    in_b_sign = bs;
    in_a_mant = a;
    in_b_mant = b;
    in_op     = op;
    in_tag    = tag;
  endtask

  initial begin
    int   issued;
    int   start;
    bit   saw_low;
    bit   xfer;
    res_t zero_res;

    //                as    bs    a          b          op    tag    {sign, eff, mag, zero, tag}
    vt[0] = '{1'b0, 1'b0, 24'h800000, 24'h800000, 1'b0, 4'h1, '{1'b0, 1'b0, 25'h1000000, 1'b0, 4'h1}};
    vt[1] = '{1'b0, 1'b0, 24'hC00000, 24'h800000, 1'b1, 4'h2, '{1'b0, 1'b1, 25'h0400000, 1'b0, 4'h2}};
    vt[2] = '{1'b0, 1'b0, 24'h800000, 24'hC00000, 1'b1, 4'h3, '{1'b1, 1'b1, 25'h0400000, 1'b0, 4'h3}};
    vt[3] = '{1'b0, 1'b1, 24'h800000, 24'hC00000, 1'b0, 4'h4, '{1'b1, 1'b1, 25'h0400000, 1'b0, 4'h4}};
    vt[4] = '{1'b0, 1'b0, 24'hA00000, 24'hA00000, 1'b1, 4'h5, '{1'b0, 1'b1, 25'h0000000, 1'b1, 4'h5}};
    vt[5] = '{1'b1, 1'b1, 24'hA00000, 24'hA00000, 1'b1, 4'h6, '{1'b0, 1'b1, 25'h0000000, 1'b1, 4'h6}};
    vt[6] = '{1'b1, 1'b1, 24'h000000, 24'h000000, 1'b0, 4'h7, '{1'b1, 1'b0, 25'h0000000, 1'b1, 4'h7}};
    vt[7] = '{1'b0, 1'b1, 24'h000000, 24'h000000, 1'b1, 4'h8, '{1'b0, 1'b0, 25'h0000000, 1'b1, 4'h8}};
    vt[8] = '{1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'h9, '{1'b0, 1'b0, 25'h1FFFFFE, 1'b0, 4'h9}};
    vt[9] = '{1'b1, 1'b0, 24'h000001, 24'hFFFFFF, 1'b0, 4'hA, '{1'b0, 1'b1, 25'h0FFFFFE, 1'b0, 4'hA}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 1'b0, '0, '0, 1'b0, '0);
    zero_res  = '0;
    repeat (3) tick();
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_res("rst_outputs", cur_out(), zero_res);
    rst = 1'b0;
    check_bit("rst_in_ready", in_ready, 1'b1);

    // Directed vectors, one at a time: latency and exact results
    for (int i = 0; i < 10; i++) begin
      set_in(vt[i].as, vt[i].bs, vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_bit("lat1_out_valid", out_valid, 1'b0);
      tick();
      check_bit("lat2_out_valid", out_valid, 1'b1);
      check_res($sformatf("vec%0d", i), cur_out(), vt[i].exp);
      tick();
    end

    // Back-to-back stream of 8 with out_ready low in cycles 3..5
    issued  = 0;
    saw_low = 0;
    start   = n_out;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (issued < 8);
      if (in_valid)
        set_in(issued[0], issued[1], 24'h800000 | (24'(issued) * 24'h011111), 24'h400000 + 24'(issued),
               issued[2], 4'(issued));
      if (!in_ready) saw_low = 1;
      xfer = in_valid && in_ready;
      tick();
      if (xfer) issued++;
    end
    in_valid = 1'b0;
    check_bit("bp_in_ready_low", saw_low, 1'b1);
    check_bit("bp_all_out", (n_out - start) == 8, 1'b1);

    // Randomised traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      logic [MW-1:0] a;
      logic [MW-1:0] b;
      a = MW'($urandom());
      b = MW'($urandom());
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = MW'($urandom_range(0, 3)); b = MW'($urandom_range(0, 3)); end
        default: ;
      endcase
      set_in(1'($urandom()), 1'($urandom()), a, b, 1'($urandom()), TW'($urandom()));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    check_bit("drain_empty", exp_q.size() == 0, 1'b1);

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(1'b0, 1'b0, 24'h123456, 24'h654321, 1'b0, 4'hC);
    tick();
    set_in(1'b1, 1'b0, 24'h111111, 24'h222222, 1'b1, 4'hD);
    tick();
    in_valid = 1'b0;
    check_bit("inflight_valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    check_bit("rst_flush", out_valid, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b1;
    check_bit("rst_flush_in_ready", in_ready, 1'b1);
    start = n_out;
    repeat (10) tick();
    check_bit("no_stale", n_out == start, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
